// File: rtl/branch_predict.sv
// Branch predictor: 2-bit saturating-counter pattern table, optional gshare index.
// Latency: fetch prediction is combinational; it reaches decode one cycle later through the F/D register.
// Backpressure: stall_d holds F/D and blocks training; flush_d clears F/D; rst (active-low, synchronous) overrides both.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous active-low reset
//   pc_f           fetch-stage PC used to index the pattern table
//   pred_taken_f   combinational taken prediction for pc_f
//   stall_d        F/D hold; also suppresses training
//   flush_d        F/D clear; has priority over stall_d
//   branch_d       decode-stage instruction is a conditional branch
//   actual_taken_d resolved branch outcome in decode
//   pred_taken_d   prediction carried alongside the decode-stage instruction
//   mispredict_d   decode-stage mispredict, for redirect/flush
//   branch_cnt     saturating count of resolved branches
//   mispred_cnt    saturating count of mispredicted branches
module branch_predict #(
    parameter int IDX_W   = 6,     // must be >= 2
    parameter bit HIST_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_d,
    input  logic        actual_taken_d,
    output logic        pred_taken_d,
    output logic        mispredict_d,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       pht [ENTRIES];
    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_d;
    logic             upd;
    logic [1:0]       cur_ctr;
    logic [1:0]       nxt_ctr;

    // PC bits outside the index field carry no information for the table.
    logic unused_pc;
    assign unused_pc = ^{pc_f[31:IDX_W+2], pc_f[1:0]};

    // Fetch index always uses the pre-update history, even in a training cycle.
    assign idx_f = HIST_EN ? (pc_f[IDX_W+1:2] ^ ghr) : pc_f[IDX_W+1:2];

    assign upd          = rst & branch_d & ~stall_d;
    assign mispredict_d = upd & (pred_taken_d ^ actual_taken_d);

    // Training always targets the index captured at fetch, not a recomputed one.
    assign cur_ctr = pht[idx_d];

    always_comb begin
        nxt_ctr = cur_ctr;
        if (actual_taken_d) begin
            if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
        end
    end

    // Write-to-read bypass so fetch sees the counter value being written this cycle.
    always_comb begin
        pred_taken_f = pht[idx_f][1];
        if (upd && (idx_f == idx_d)) pred_taken_f = nxt_ctr[1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
            ghr          <= '0;
            pred_taken_d <= 1'b0;
            idx_d        <= '0;
            branch_cnt   <= '0;
            mispred_cnt  <= '0;
        end else begin
            if (flush_d) begin
                pred_taken_d <= 1'b0;
                idx_d        <= '0;
            end else if (!stall_d) begin
                pred_taken_d <= pred_taken_f;
                idx_d        <= idx_f;
            end

            if (upd) begin
                pht[idx_d] <= nxt_ctr;
                if (HIST_EN) ghr <= {ghr[IDX_W-2:0], actual_taken_d};
                if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
                if (mispredict_d && (mispred_cnt != 32'hFFFF_FFFF))
                    mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict.sv
// Testbench for branch_predict: directed vectors, expectations queued by the stimulus
// and checked by an independent negedge monitor. Two instances share the stimulus:
// dut (gshare, default) and dut0 (PC-only indexing).
module tb_branch_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        stall_d, flush_d, branch_d, actual_taken_d;

    logic        pred_taken_f, pred_taken_d, mispredict_d;
    logic [31:0] branch_cnt, mispred_cnt;
    logic        pred_taken_f0, pred_taken_d0, mispredict_d0;
    logic [31:0] branch_cnt0, mispred_cnt0;

    always #5 clk = ~clk;

    branch_predict dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .stall_d(stall_d), .flush_d(flush_d), .branch_d(branch_d),
        .actual_taken_d(actual_taken_d), .pred_taken_d(pred_taken_d),
        .mispredict_d(mispredict_d), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_predict #(.IDX_W(6), .HIST_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f0),
        .stall_d(stall_d), .flush_d(flush_d), .branch_d(branch_d),
        .actual_taken_d(actual_taken_d), .pred_taken_d(pred_taken_d0),
        .mispredict_d(mispredict_d0), .branch_cnt(branch_cnt0), .mispred_cnt(mispred_cnt0)
    );

    localparam int S_PTF  = 0;
    localparam int S_PTD  = 1;
    localparam int S_MIS  = 2;
    localparam int S_BC   = 3;
    localparam int S_MC   = 4;
    localparam int S_GHR  = 5;
    localparam int S_PHT  = 6;
    localparam int S_PTF0 = 7;
    localparam int S_MIS0 = 8;
    localparam int S_MC0  = 9;
    localparam int S_BC0  = 10;
    localparam int S_GHR0 = 11;
    localparam int S_PHT0 = 12;

    typedef struct {
        int          cyc;
        int          sig;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int sig, input int idx);
        case (sig)
            S_PTF:   return {31'd0, pred_taken_f};
            S_PTD:   return {31'd0, pred_taken_d};
            S_MIS:   return {31'd0, mispredict_d};
            S_BC:    return branch_cnt;
            S_MC:    return mispred_cnt;
            S_GHR:   return {26'd0, dut.ghr};
            S_PHT:   return {30'd0, dut.pht[idx]};
            S_PTF0:  return {31'd0, pred_taken_f0};
            S_MIS0:  return {31'd0, mispredict_d0};
            S_MC0:   return mispred_cnt0;
            S_BC0:   return branch_cnt0;
            S_GHR0:  return {26'd0, dut0.ghr};
            S_PHT0:  return {30'd0, dut0.pht[idx]};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    exp_t mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = get_sig(mon_e.sig, mon_e.idx);
            total++;
            if (mon_act !== mon_e.exp) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                         mon_e.name, mon_act, mon_e.exp, cyc);
            end
        end
    end

    task automatic chk(input string name, input int sig, input int idx, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.idx  = idx;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; pc_f = 32'h0; stall_d = 1'b0; flush_d = 1'b0;
        branch_d = 1'b0; actual_taken_d = 1'b0;
        tick(); tick();

        // Reset state and first resolution (gshare instance)
        rst = 1'b1; pc_f = 32'h0040_0000;
        chk("rst_ptf", S_PTF, 0, 0);
        chk("rst_ptd", S_PTD, 0, 0);
        chk("rst_mis", S_MIS, 0, 0);
        chk("rst_bc",  S_BC,  0, 0);
        chk("rst_mc",  S_MC,  0, 0);
        chk("rst_ghr", S_GHR, 0, 0);
        tick();
        branch_d = 1'b1; actual_taken_d = 1'b1;
        chk("a_mis",    S_MIS, 0, 1);
        chk("a_bypass", S_PTF, 0, 1);
        tick();
        branch_d = 1'b0;
        chk("a_bc",   S_BC,  0, 1);
        chk("a_mc",   S_MC,  0, 1);
        chk("a_ghr",  S_GHR, 0, 1);
        chk("a_pht0", S_PHT, 0, 2);
        chk("a_ptd",  S_PTD, 0, 1);
        chk("a_ptf",  S_PTF, 0, 0);

        // Bypass on idx 5, fetch index built from pre-update history
        rst = 1'b0; tick();
        rst = 1'b1; pc_f = 32'h14; tick();
        branch_d = 1'b1; actual_taken_d = 1'b1;
        chk("b_bypass", S_PTF, 0, 1);
        chk("b_mis",    S_MIS, 0, 1);
        tick();
        branch_d = 1'b0;
        chk("b_pht5", S_PHT, 5, 2);
        chk("b_ghr",  S_GHR, 0, 1);
        chk("b_ptd",  S_PTD, 0, 1);
        chk("b_ptf",  S_PTF, 0, 0);

        // Stall blocks training for 3 cycles, then exactly one update
        stall_d = 1'b1; branch_d = 1'b1; actual_taken_d = 1'b0; pc_f = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("c_mis",  S_MIS, 0, 0);
            chk("c_ptd",  S_PTD, 0, 1);
            chk("c_bc",   S_BC,  0, 1);
            chk("c_ghr",  S_GHR, 0, 1);
            chk("c_pht5", S_PHT, 5, 2);
            tick();
        end
        stall_d = 1'b0;
        chk("c_mis_rel", S_MIS, 0, 1);
        tick();
        branch_d = 1'b0;
        chk("c_bc2",  S_BC,  0, 2);
        chk("c_mc2",  S_MC,  0, 2);
        chk("c_pht5b", S_PHT, 5, 1);
        chk("c_ghr2", S_GHR, 0, 2);
        chk("c_ptd0", S_PTD, 0, 0);

        // Flush beats stall
        pc_f = 32'h1C; tick();
        branch_d = 1'b1; actual_taken_d = 1'b1;
        chk("d_bypass", S_PTF, 0, 1);
        tick();
        branch_d = 1'b0;
        chk("d_ptd", S_PTD, 0, 1);
        chk("d_ghr", S_GHR, 0, 5);
        flush_d = 1'b1; stall_d = 1'b1; tick();
        flush_d = 1'b0; stall_d = 1'b0;
        chk("d_flush",    S_PTD, 0, 0);
        chk("d_ghr_hold", S_GHR, 0, 5);

        // Train 10 taken, then reset with a branch pending
        branch_d = 1'b1; actual_taken_d = 1'b1; pc_f = 32'h0;
        repeat (10) tick();
        rst = 1'b0;
        chk("e_bc_pre",  S_BC,  0, 13);
        chk("e_rst_mis", S_MIS, 0, 0);
        tick();
        rst = 1'b1; branch_d = 1'b0;
        chk("e_bc",  S_BC,  0, 0);
        chk("e_mc",  S_MC,  0, 0);
        chk("e_ghr", S_GHR, 0, 0);
        chk("e_ptd", S_PTD, 0, 0);
        for (int i = 0; i < 64; i++) chk("e_pht", S_PHT, i, 1);
        begin
            logic [31:0] pcs [4];
            pcs[0] = 32'h0; pcs[1] = 32'h0040_0004; pcs[2] = 32'h1234_5678; pcs[3] = 32'hFFFF_FFFC;
            for (int i = 0; i < 4; i++) begin
                pc_f = pcs[i];
                chk("e_ptf", S_PTF, 0, 0);
                tick();
            end
        end

        // PC-only instance: entry 4 trained taken x3, then one not-taken
        pc_f = 32'h10; branch_d = 1'b0; tick();
        branch_d = 1'b1; actual_taken_d = 1'b1;
        chk("f_mis0", S_MIS0, 0, 1);
        chk("f_ptf0", S_PTF0, 0, 1);
        tick();
        chk("f_pht4a", S_PHT0, 4, 2);
        chk("f_mis0b", S_MIS0, 0, 0);
        tick();
        chk("f_pht4b", S_PHT0, 4, 3);
        tick();
        actual_taken_d = 1'b0;
        chk("f_mc0a",  S_MC0,  0, 1);
        chk("f_pht4c", S_PHT0, 4, 3);
        chk("f_ptf0b", S_PTF0, 0, 1);
        chk("f_mis0c", S_MIS0, 0, 1);
        tick();
        branch_d = 1'b0;
        chk("f_pht4d", S_PHT0, 4, 2);
        chk("f_ptf0c", S_PTF0, 0, 1);
        chk("f_mc0b",  S_MC0,  0, 2);
        chk("f_bc0",   S_BC0,  0, 4);
        chk("f_ghr0",  S_GHR0, 0, 0);
        tick();

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict.md
BRANCH_PREDICT -- requirements
Module: branch_predict

Interface
REQ-001 The module SHALL have parameter IDX_W, default 6, setting the pattern table index width (2^IDX_W two-bit entries).
REQ-002 The module SHALL have parameter HIST_EN, default 1, where 1 selects gshare indexing and 0 selects PC-only indexing.
REQ-003 The module SHALL have port clk, input, 1 bit: the only clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port pc_f, input, 32 bits: fetch-stage PC.
REQ-006 The module SHALL have port pred_taken_f, output, 1 bit: combinational taken prediction for pc_f.
REQ-007 The module SHALL have port stall_d, input, 1 bit: F/D pipeline register hold.
REQ-008 The module SHALL have port flush_d, input, 1 bit: F/D pipeline register clear.
REQ-009 The module SHALL have port branch_d, input, 1 bit: the decode-stage instruction is a conditional branch (BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ/BLTZAL/BGEZAL).
REQ-010 The module SHALL have port actual_taken_d, input, 1 bit: resolved outcome from the decode-stage branch comparator.
REQ-011 The module SHALL have port pred_taken_d, output, 1 bit: the registered prediction carried with the decode-stage instruction.
REQ-012 The module SHALL have port mispredict_d, output, 1 bit: decode-stage mispredict, consumed by the hazard unit for redirect/flush.
REQ-013 The module SHALL have port branch_cnt, output, 32 bits: count of resolved branches.
REQ-014 The module SHALL have port mispred_cnt, output, 32 bits: count of mispredicted branches.

Function
REQ-015 The fetch index SHALL be idx_f = pc_f[IDX_W+1:2] XOR ghr[IDX_W-1:0] when HIST_EN=1, and pc_f[IDX_W+1:2] when HIST_EN=0; ghr is an IDX_W-bit global history register.
REQ-016 Each pattern table entry SHALL be a 2-bit saturating counter, and pred_taken_f SHALL equal bit[1] of entry idx_f.
REQ-017 The F/D register SHALL capture {pred_taken_f, idx_f} into {pred_taken_d, idx_d} on an edge with rst=1, stall_d=0 and flush_d=0.
REQ-018 The F/D register SHALL hold its value on an edge with stall_d=1 and flush_d=0.
REQ-019 The F/D register SHALL clear pred_taken_d and idx_d to 0 on an edge with flush_d=1; flush_d has priority over stall_d.
REQ-020 The update condition upd SHALL be rst=1 AND branch_d=1 AND stall_d=0.
REQ-021 mispredict_d SHALL be combinational and SHALL equal upd AND (pred_taken_d != actual_taken_d).
REQ-022 On upd, entry idx_d SHALL increment, saturating at 2'b11, when actual_taken_d=1, and decrement, saturating at 2'b00, when actual_taken_d=0.
REQ-023 On upd, ghr SHALL become {ghr[IDX_W-2:0], actual_taken_d}; with HIST_EN=0, ghr SHALL stay 0.
REQ-024 The update SHALL use the stored idx_d, never a recomputed index.
REQ-025 When upd=1 and idx_f == idx_d in the same cycle, pred_taken_f SHALL reflect the post-update counter value (write-to-read bypass).
REQ-026 The ghr value used for idx_f in an update cycle SHALL be the pre-update ghr.
REQ-027 On upd, branch_cnt SHALL increment by 1.
REQ-028 On upd with mispredict_d=1, mispred_cnt SHALL increment by 1.
REQ-029 branch_cnt and mispred_cnt SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-030 While stall_d=1, no counter, ghr or statistics change SHALL occur, and mispredict_d SHALL be 0.

Reset
REQ-031 On an edge with rst=0, every pattern entry SHALL be set to 2'b01 (weakly not-taken), all in the same cycle.
REQ-032 On an edge with rst=0, ghr, pred_taken_d, idx_d, branch_cnt and mispred_cnt SHALL be set to 0.
REQ-033 rst=0 SHALL override stall_d, flush_d and branch_d, and no update SHALL occur in a reset cycle.
REQ-034 After reset, pred_taken_f SHALL read 0 for every PC.
REQ-035 After reset, mispredict_d SHALL be 0 until the first upd.
REQ-036 Reset asserted mid-operation SHALL discard all trained state, with no partial update of the entry being written.

Verification
REQ-037 Reset; pc_f=0x00400000 -> pred_taken_f=0; next cycle branch_d=1, actual_taken_d=1 -> mispredict_d=1; after the edge branch_cnt=1, mispred_cnt=1, ghr=6'b000001.
REQ-038 HIST_EN=0, pc 0x00000010 resolved taken 3 times -> entry 4 = 2'b11, pred_taken_f=1; one not-taken -> entry 2'b10, prediction still 1, mispred_cnt incremented on that resolution only.
REQ-039 upd to idx 5 moving its counter 01->10 while idx_f=5 -> pred_taken_f=1 in the same cycle.
REQ-040 stall_d=1 with branch_d=1 for 3 cycles -> mispredict_d=0; counters, ghr, branch_cnt and pred_taken_d unchanged; the single update occurs on the first cycle with stall_d=0.
REQ-041 flush_d=1 with stall_d=1 and pred_taken_d=1 -> pred_taken_d=0 after the edge.
REQ-042 Train 10 taken branches, then rst=0 for one cycle -> all predictions 0, ghr=0, both counters 0, no update in the reset cycle.
